// File: rtl/imm_instr_encoder.sv
// Packs an immediate plus register/opcode fields into an RV32 instruction word.
// Two-stage valid/ready pipeline; non-encodable requests emit NOP_INSTR with imm_err set.
module imm_instr_encoder #(
    parameter int          ERR_CNT_W = 8,
    parameter logic [31:0] NOP_INSTR = 32'h00000013
) (
    input  logic                 CLK,
    input  logic                 RESET,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [31:0]          imm,
    input  logic [2:0]           imm_sel,
    input  logic [6:0]           opcode,
    input  logic [4:0]           rd,
    input  logic [4:0]           rs1,
    input  logic [4:0]           rs2,
    input  logic [2:0]           funct3,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [31:0]          instr,
    output logic                 imm_err,
    output logic [ERR_CNT_W-1:0] err_count
);

    // Immediate type codes, matching the ID-stage immediate generator.
    localparam logic [2:0] I_TYPE = 3'd0;
    localparam logic [2:0] S_TYPE = 3'd1;
    localparam logic [2:0] B_TYPE = 3'd2;
    localparam logic [2:0] U_TYPE = 3'd3;
    localparam logic [2:0] J_TYPE = 3'd4;

    logic                 s1_valid_q, s2_valid_q;
    logic                 s1_err_q, s1_err_d;
    logic [31:0]          s1_imm_q;
    logic [2:0]           s1_sel_q, s1_f3_q;
    logic [6:0]           s1_opc_q;
    logic [4:0]           s1_rd_q, s1_rs1_q, s1_rs2_q;
    logic [31:0]          s2_instr_q, s2_instr_d;
    logic                 s2_err_q;
    logic [ERR_CNT_W-1:0] err_count_q, err_count_d;
    logic                 s1_adv, s2_adv;

    assign s2_adv   = !s2_valid_q || out_ready;
    assign s1_adv   = !s1_valid_q || s2_adv;
    assign in_ready = s1_adv;

    // NOTE: every signal written in always_comb gets a default first, so no path infers a latch.
    always_comb begin
        s1_err_d = 1'b1;
        case (imm_sel)
            I_TYPE, S_TYPE: s1_err_d = !((&imm[31:11]) || !(|imm[31:11]));
            B_TYPE:         s1_err_d = !((&imm[31:12]) || !(|imm[31:12])) || imm[0];
            J_TYPE:         s1_err_d = !((&imm[31:20]) || !(|imm[31:20])) || imm[0];
            U_TYPE:         s1_err_d = |imm[11:0];
            default:        s1_err_d = 1'b1;
        endcase
    end

    always_comb begin
        s2_instr_d = NOP_INSTR;
        if (!s1_err_q) begin
            case (s1_sel_q)
                I_TYPE: s2_instr_d = {s1_imm_q[11:0], s1_rs1_q, s1_f3_q, s1_rd_q, s1_opc_q};
                S_TYPE: s2_instr_d = {s1_imm_q[11:5], s1_rs2_q, s1_rs1_q, s1_f3_q,
                                      s1_imm_q[4:0], s1_opc_q};
                B_TYPE: s2_instr_d = {s1_imm_q[12], s1_imm_q[10:5], s1_rs2_q, s1_rs1_q, s1_f3_q,
                                      s1_imm_q[4:1], s1_imm_q[11], s1_opc_q};
                U_TYPE: s2_instr_d = {s1_imm_q[31:12], s1_rd_q, s1_opc_q};
                J_TYPE: s2_instr_d = {s1_imm_q[20], s1_imm_q[10:1], s1_imm_q[11],
                                      s1_imm_q[19:12], s1_rd_q, s1_opc_q};
                default: s2_instr_d = NOP_INSTR;
            endcase
        end
    end

    always_comb begin
        err_count_d = err_count_q;
        if (s2_valid_q && out_ready && s2_err_q && !(&err_count_q))
            err_count_d = err_count_q + 1'b1;
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            s1_valid_q  <= 1'b0;
            s2_valid_q  <= 1'b0;
            s2_instr_q  <= '0;
            s2_err_q    <= 1'b0;
            err_count_q <= '0;
        end else begin
            err_count_q <= err_count_d;
            if (s1_adv) s1_valid_q <= in_valid;
            if (s2_adv) begin
                s2_valid_q <= s1_valid_q;
                if (s1_valid_q) begin
                    s2_instr_q <= s2_instr_d;
                    s2_err_q   <= s1_err_q;
                end
            end
        end
    end

    // NOTE: stage-1 payload is qualified by s1_valid_q, so it carries no reset.
    always_ff @(posedge CLK) begin
        if (s1_adv && in_valid) begin
            s1_err_q <= s1_err_d;
            s1_imm_q <= imm;
            s1_sel_q <= imm_sel;
            s1_f3_q  <= funct3;
            s1_opc_q <= opcode;
            s1_rd_q  <= rd;
            s1_rs1_q <= rs1;
            s1_rs2_q <= rs2;
        end
    end

    assign out_valid = s2_valid_q;
    assign instr     = s2_instr_q;
    assign imm_err   = s2_err_q;
    assign err_count = err_count_q;

endmodule

// File: tb/tb_imm_instr_encoder.sv
// Scoreboard bench for imm_instr_encoder: expectations are queued on accept and
// compared on every output handshake.
module tb_imm_instr_encoder;

    localparam logic [2:0] I_T = 3'd0, S_T = 3'd1, B_T = 3'd2, U_T = 3'd3, J_T = 3'd4;
    localparam logic [31:0] NOP = 32'h00000013;

    logic        CLK = 1'b0;
    logic        RESET = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] imm = '0;
    logic [2:0]  imm_sel = '0;
    logic [6:0]  opcode = '0;
    logic [4:0]  rd = '0, rs1 = '0, rs2 = '0;
    logic [2:0]  funct3 = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] instr;
    logic        imm_err;
    logic [7:0]  err_count;

    imm_instr_encoder #(.ERR_CNT_W(8), .NOP_INSTR(NOP)) dut (
        .CLK(CLK), .RESET(RESET),
        .in_valid(in_valid), .in_ready(in_ready),
        .imm(imm), .imm_sel(imm_sel), .opcode(opcode),
        .rd(rd), .rs1(rs1), .rs2(rs2), .funct3(funct3),
        .out_valid(out_valid), .out_ready(out_ready),
        .instr(instr), .imm_err(imm_err), .err_count(err_count)
    );

    always #5 CLK = ~CLK;

    int          n_checks = 0;
    int          n_pass = 0;
    logic [32:0] sb[$];
    logic [32:0] cur_exp = '0;
    logic [7:0]  exp_cnt = '0;
    logic        hold_v = 1'b0;
    logic [31:0] hold_instr = '0;
    logic        hold_err = 1'b0;
    logic        rand_ready = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    endtask

    // Reference encoder: range checks done on the signed value.
    function automatic logic [32:0] model(input logic [31:0] i, input logic [2:0] sel,
                                          input logic [6:0] opc, input logic [4:0] d,
                                          input logic [4:0] a, input logic [4:0] b,
                                          input logic [2:0] f3);
        int          s;
        logic        ok;
        logic [31:0] w;
        s  = $signed(i);
        ok = 1'b0;
        w  = NOP;
        case (sel)
            I_T: begin ok = (s >= -2048) && (s <= 2047); w = {i[11:0], a, f3, d, opc}; end
            S_T: begin ok = (s >= -2048) && (s <= 2047); w = {i[11:5], b, a, f3, i[4:0], opc}; end
            B_T: begin
                ok = (s >= -4096) && (s <= 4094) && (i[0] == 1'b0);
                w  = {i[12], i[10:5], b, a, f3, i[4:1], i[11], opc};
            end
            U_T: begin ok = (i[11:0] == 12'h000); w = {i[31:12], d, opc}; end
            J_T: begin
                ok = (s >= -1048576) && (s <= 1048574) && (i[0] == 1'b0);
                w  = {i[20], i[10:1], i[11], i[19:12], d, opc};
            end
            default: ok = 1'b0;
        endcase
        return ok ? {1'b0, w} : {1'b1, NOP};
    endfunction

    // Monitor: compares outputs, tracks the error counter, queues accepted requests.
    always @(negedge CLK) begin
        logic [32:0] e;
        if (RESET) begin
            sb.delete();
            exp_cnt = '0;
            hold_v  = 1'b0;
        end else begin
            check("err_count", {24'd0, err_count}, {24'd0, exp_cnt});
            if (hold_v) begin
                check("stall_instr", instr, hold_instr);
                check("stall_err", {31'd0, imm_err}, {31'd0, hold_err});
            end
            hold_v     = out_valid && !out_ready;
            hold_instr = instr;
            hold_err   = imm_err;
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    check("spurious_out", instr, 32'hDEAD_BEEF);
                end else begin
                    e = sb.pop_front();
                    check("instr", instr, e[31:0]);
                    check("imm_err", {31'd0, imm_err}, {31'd0, e[32]});
                    if (e[32] && exp_cnt != 8'hFF) exp_cnt = exp_cnt + 8'd1;
                end
            end
            if (in_valid && in_ready) sb.push_back(cur_exp);
        end
    end

    // Called just after a rising edge; returns just after the accepting edge with in_valid still high.
    task automatic send(input logic [31:0] i, input logic [2:0] sel, input logic [6:0] opc,
                        input logic [4:0] d, input logic [4:0] a, input logic [4:0] b,
                        input logic [2:0] f3, input logic [32:0] exp);
        imm = i; imm_sel = sel; opcode = opc; rd = d; rs1 = a; rs2 = b; funct3 = f3;
        cur_exp  = exp;
        in_valid = 1'b1;
        for (int n = 0; n < 200; n++) begin
            @(negedge CLK);
            if (in_ready) begin
                @(posedge CLK); #1;
                if (rand_ready) out_ready = ($urandom_range(0, 3) != 0);
                return;
            end
            @(posedge CLK); #1;
            if (rand_ready) out_ready = ($urandom_range(0, 3) != 0);
        end
        check("send_timeout", 32'd0, 32'd1);
        in_valid = 1'b0;
    endtask

    task automatic send_m(input logic [31:0] i, input logic [2:0] sel, input logic [6:0] opc,
                          input logic [4:0] d, input logic [4:0] a, input logic [4:0] b,
                          input logic [2:0] f3);
        send(i, sel, opc, d, a, b, f3, model(i, sel, opc, d, a, b, f3));
    endtask

    task automatic drain();
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int n = 0; n < 200 && sb.size() != 0; n++) begin
            @(posedge CLK); #1;
        end
        repeat (2) @(posedge CLK);
        #1;
        check("drain_empty", sb.size(), 32'd0);
    endtask

    logic [31:0] edge_imm[11] = '{32'd2047, 32'd2048, 32'hFFFFF800, 32'hFFFFF7FF, 32'd4094,
                                  32'd4096, 32'hFFFFF000, 32'hFFFFEFFF, 32'd1, 32'd3, 32'h000FFFFE};

    initial begin
        #200000;
        $display("FAIL global_timeout");
        $fatal(1, "bench timeout");
    end

    initial begin
        logic [31:0] ri;
        logic [2:0]  rs;
        repeat (3) @(posedge CLK);
        #1;
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_instr", instr, 32'd0);
        check("rst_imm_err", {31'd0, imm_err}, 32'd0);
        check("rst_err_count", {24'd0, err_count}, 32'd0);
        RESET = 1'b0;
        @(negedge CLK);
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);
        @(posedge CLK); #1;

        // Directed vectors with literal expectations, plus latency of the first one.
        send(32'hFFFFFFFF, I_T, 7'h13, 5'd1, 5'd2, 5'd0, 3'd0, {1'b0, 32'hFFF10093});
        in_valid = 1'b0;
        @(negedge CLK);
        check("lat_cycle1", {31'd0, out_valid}, 32'd0);
        @(negedge CLK);
        check("lat_cycle2", {31'd0, out_valid}, 32'd1);
        @(posedge CLK); #1;
        send(32'hFFFFFFFC, B_T, 7'h63, 5'd0, 5'd1, 5'd2, 3'd0, {1'b0, 32'hFE208EE3});
        send(32'h00000800, J_T, 7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, {1'b0, 32'h001000EF});
        send(32'h12345000, U_T, 7'h37, 5'd5, 5'd0, 5'd0, 3'd0, {1'b0, 32'h123452B7});
        send(32'h12345001, U_T, 7'h37, 5'd5, 5'd0, 5'd0, 3'd0, {1'b1, NOP});
        drain();
        check("err_count_one", {24'd0, err_count}, 32'd1);

        send(32'd3,    B_T, 7'h63, 5'd0, 5'd1, 5'd2, 3'd0, {1'b1, NOP});
        send(32'd2048, I_T, 7'h13, 5'd1, 5'd2, 5'd0, 3'd0, {1'b1, NOP});
        send(32'd4,    3'd7, 7'h13, 5'd1, 5'd2, 5'd0, 3'd0, {1'b1, NOP});
        send(32'h0000_07F0, S_T, 7'h23, 5'd0, 5'd3, 5'd4, 3'd2, model(32'h7F0, S_T, 7'h23, 5'd0, 5'd3, 5'd4, 3'd2));
        drain();

        // Randomised mix with random backpressure.
        rand_ready = 1'b1;
        for (int k = 0; k < 80; k++) begin
            rs = 3'($urandom_range(0, 7));
            case ($urandom_range(0, 3))
                0: ri = $urandom;
                1: ri = 32'($urandom_range(0, 8191)) - 32'd4096;
                2: ri = edge_imm[$urandom_range(0, 10)];
                default: ri = $urandom & 32'hFFFFF000;
            endcase
            send_m(ri, rs, 7'($urandom), 5'($urandom), 5'($urandom), 5'($urandom), 3'($urandom));
        end
        rand_ready = 1'b0;
        drain();

        // Backpressure: five back-to-back requests while the consumer stalls.
        out_ready = 1'b0;
        fork
            begin
                for (int k = 0; k < 5; k++)
                    send_m(32'd16 * k, I_T, 7'h13, 5'(k + 1), 5'd7, 5'd0, 3'd0);
                in_valid = 1'b0;
            end
            begin
                repeat (2) @(posedge CLK);
                @(negedge CLK);
                check("bp_in_ready_low", {31'd0, in_ready}, 32'd0);
                repeat (3) @(posedge CLK);
                #1 out_ready = 1'b1;
            end
        join
        drain();

        // Error counter saturation.
        for (int k = 0; k < 300; k++)
            send(32'd1, 3'd5, 7'h13, 5'd0, 5'd0, 5'd0, 3'd0, {1'b1, NOP});
        drain();
        check("err_count_sat", {24'd0, err_count}, 32'h000000FF);

        // Reset with two requests in flight.
        out_ready = 1'b0;
        send_m(32'd5, I_T, 7'h13, 5'd9, 5'd1, 5'd0, 3'd0);
        send_m(32'd6, I_T, 7'h13, 5'd10, 5'd1, 5'd0, 3'd0);
        in_valid = 1'b0;
        RESET = 1'b1;
        @(posedge CLK); #1;
        check("mid_rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("mid_rst_err_count", {24'd0, err_count}, 32'd0);
        check("mid_rst_instr", instr, 32'd0);
        RESET = 1'b0;
        out_ready = 1'b1;
        repeat (5) @(posedge CLK);
        #1;
        check("post_rst_no_output", {31'd0, out_valid}, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
